// File: rtl/mac_seq_ctrl.sv
// Command sequencer in front of the MAC: accepts one job, streams its operand
// beats into the MAC lanes, captures the final C value and returns it on a ready/valid port.
module mac_seq_ctrl #(
    parameter int MIN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int CONF_WIDTH = 3,
    parameter int LEN_WIDTH  = 8,
    parameter int RES_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_mode,
    input  logic                          cmd_acc,
    input  logic [ACC_WIDTH-1:0]          cmd_init,
    input  logic [LEN_WIDTH-1:0]          cmd_len,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [4*MIN_WIDTH-1:0]        op_a,
    input  logic [MIN_WIDTH-1:0]          op_b,
    output logic [MIN_WIDTH-1:0]          mac_a,
    output logic [MIN_WIDTH-1:0]          mac_dual,
    output logic [MIN_WIDTH-1:0]          mac_quad1,
    output logic [MIN_WIDTH-1:0]          mac_quad2,
    output logic [MIN_WIDTH-1:0]          mac_b,
    output logic                          mac_en,
    output logic                          mac_acc_clr,
    output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
    input  logic [ACC_WIDTH-1:0]          mac_c,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_WIDTH-1:0]          res_data,
    output logic                          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              mode_q;
    logic                    acc_q;
    logic [ACC_WIDTH-1:0]    init_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_cnt;
    logic [LEN_WIDTH-1:0]    last_beat;
    logic [1:0]              wait_cnt;
    logic                    wait_last;
    logic [CONF_WIDTH-1:0]   conf;

    // Counter compares against len-1 so len = 2^LEN_WIDTH-1 finishes before any wrap.
    assign last_beat = len_q - LEN_WIDTH'(1);
    assign wait_last = (wait_cnt == 2'(RES_LAT - 1));
    assign busy      = (state != S_IDLE);

    always_comb begin
        conf                 = '0;
        conf[1:0]            = mode_q;
        conf[CONF_WIDTH-1]   = acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt   = state;
        cmd_ready   = 1'b0;
        op_ready    = 1'b0;
        mac_en      = 1'b0;
        mac_acc_clr = 1'b0;
        res_valid   = 1'b0;
        mac_a       = '0;
        mac_dual    = '0;
        mac_quad1   = '0;
        mac_quad2   = '0;
        mac_b       = '0;
        mac_cfg     = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                mac_acc_clr = 1'b1;
                mac_cfg     = {init_q, conf};
                state_nxt   = S_RUN;
            end
            S_RUN: begin
                op_ready  = 1'b1;
                mac_en    = op_valid;
                mac_cfg   = {init_q, conf};
                mac_a     = op_a[0*MIN_WIDTH +: MIN_WIDTH];
                mac_dual  = op_a[1*MIN_WIDTH +: MIN_WIDTH];
                mac_quad1 = op_a[2*MIN_WIDTH +: MIN_WIDTH];
                mac_quad2 = op_a[3*MIN_WIDTH +: MIN_WIDTH];
                mac_b     = op_b;
                if (op_valid && (beat_cnt == last_beat)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                mac_cfg = {init_q, conf};
                if (wait_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            acc_q    <= 1'b0;
            init_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            res_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q <= cmd_mode;
                        acc_q  <= cmd_acc;
                        init_q <= cmd_init;
                        len_q  <= cmd_len;
                        // Zero-length jobs skip the MAC entirely.
                        if (cmd_len == '0) begin
                            res_data <= cmd_acc ? cmd_init : '0;
                        end
                    end
                end
                S_LOAD: begin
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                end
                S_RUN: begin
                    if (op_valid) begin
                        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_last) begin
                        res_data <= mac_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: behavioural MAC stand-in, table vectors,
// hand-written corner sequences and randomized jobs checked against a job-level model.
module tb_mac_seq_ctrl;

    localparam int MW = 8;
    localparam int AW = 32;
    localparam int CW = 3;
    localparam int LW = 8;
    localparam int RL = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic              cmd_acc;
    logic [AW-1:0]     cmd_init;
    logic [LW-1:0]     cmd_len;
    logic              op_valid;
    logic              op_ready;
    logic [4*MW-1:0]   op_a;
    logic [MW-1:0]     op_b;
    logic [MW-1:0]     mac_a, mac_dual, mac_quad1, mac_quad2, mac_b;
    logic              mac_en;
    logic              mac_acc_clr;
    logic [AW+CW-1:0]  mac_cfg;
    logic [AW-1:0]     mac_c;
    logic              res_valid;
    logic              res_ready;
    logic [AW-1:0]     res_data;
    logic              busy;

    mac_seq_ctrl #(
        .MIN_WIDTH(MW), .ACC_WIDTH(AW), .CONF_WIDTH(CW), .LEN_WIDTH(LW), .RES_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_acc(cmd_acc), .cmd_init(cmd_init), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_dual(mac_dual), .mac_quad1(mac_quad1), .mac_quad2(mac_quad2),
        .mac_b(mac_b), .mac_en(mac_en), .mac_acc_clr(mac_acc_clr), .mac_cfg(mac_cfg),
        .mac_c(mac_c), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane products of the MAC: lane k result lands at bit offset 8*k.
    function automatic logic [31:0] prod(input logic [1:0] m, input logic [31:0] a, input logic [7:0] b);
        logic [31:0] p0, p1, p2, p3;
        p0 = 32'(a[7:0])   * 32'(b);
        p1 = (32'(a[15:8])  * 32'(b)) << 8;
        p2 = (32'(a[23:16]) * 32'(b)) << 16;
        p3 = (32'(a[31:24]) * 32'(b)) << 24;
        case (m)
            2'b00:   return p0;
            2'b01:   return p0 + p1;
            2'b10:   return p0 + p1 + p2 + p3;
            default: return 32'd0;
        endcase
    endfunction

    // MAC stand-in with a single output register (RES_LAT = 1).
    logic [31:0] mac_acc = 32'd0;
    assign mac_c = mac_acc;
    always @(posedge clk) begin
        if (mac_acc_clr) begin
            mac_acc <= mac_cfg[AW+CW-1:CW];
        end else if (mac_en) begin
            mac_acc <= mac_cfg[CW-1]
                ? mac_acc + prod(mac_cfg[1:0], {mac_quad2, mac_quad1, mac_dual, mac_a}, mac_b)
                : prod(mac_cfg[1:0], {mac_quad2, mac_quad1, mac_dual, mac_a}, mac_b);
        end
    end

    int en_total = 0;
    int clr_total = 0;
    int busy_ready_err = 0;
    always @(negedge clk) begin
        if (mac_en)            en_total++;
        if (mac_acc_clr)       clr_total++;
        if (busy && cmd_ready) busy_ready_err++;
    end

    logic [31:0] ba[256];
    logic [7:0]  bb[256];
    int          bg[256];

    function automatic logic [31:0] ref_result(input logic [1:0] m, input logic a,
                                               input logic [31:0] i, input int l);
        logic [31:0] s;
        s = a ? i : 32'd0;
        for (int k = 0; k < l; k++) begin
            s = a ? s + prod(m, ba[k], bb[k]) : prod(m, ba[k], bb[k]);
        end
        return s;
    endfunction

    task automatic send_cmd(input logic [1:0] m, input logic a, input logic [31:0] i, input logic [7:0] l);
        bit ok;
        ok        = 1'b0;
        cmd_mode  = m;
        cmd_acc   = a;
        cmd_init  = i;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [7:0] b, input int gap);
        bit ok;
        ok       = 1'b0;
        op_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (op_ready) begin
                ok = 1'b1;
                check("lanes", 64'({mac_quad2, mac_quad1, mac_dual, mac_a, mac_b}), 64'({a, b}));
                check("beat_en", 64'(mac_en), 64'd1);
            end
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        check("beat_accept", 64'(ok), 64'd1);
    endtask

    task automatic get_result(input logic [31:0] exp, input int rdy);
        bit          got;
        logic [31:0] held;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("res_valid_seen", 64'(got), 64'd1);
        if (got) begin
            held = res_data;
            repeat (rdy) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("hold_valid", 64'(res_valid), 64'd1);
                check("hold_data", 64'(res_data), 64'(held));
                check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(negedge clk);
            check("res_data", 64'(res_data), 64'(exp));
            check("res_valid_at_hs", 64'(res_valid), 64'd1);
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            check("res_valid_drop", 64'(res_valid), 64'd0);
            check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    // Starts right after the accept edge of a command.
    task automatic finish_job(input logic [1:0] m, input logic a, input logic [31:0] i,
                              input int l, input int rdy, input logic [31:0] exp);
        int en0, clr0;
        en0  = en_total;
        clr0 = clr_total;
        if (l != 0) begin
            @(negedge clk);
            check("cfg_load", 64'(mac_cfg), 64'({i, a, m}));
            check("busy_load", 64'(busy), 64'd1);
            @(posedge clk); #1;
            for (int k = 0; k < l; k++) drive_beat(ba[k], bb[k], bg[k]);
        end
        get_result(exp, rdy);
        check("en_count", 64'(en_total - en0), 64'(l));
        check("clr_count", 64'(clr_total - clr0), (l != 0) ? 64'd1 : 64'd0);
    endtask

    task automatic run_job(input logic [1:0] m, input logic a, input logic [31:0] i,
                           input int l, input int rdy, input logic [31:0] exp);
        send_cmd(m, a, i, 8'(l));
        finish_job(m, a, i, l, rdy, exp);
    endtask

    typedef struct {
        logic [1:0]       mode;
        logic             acc;
        logic [31:0]      init;
        int               len;
        logic [3:0][31:0] a;     // beat k in element k
        logic [3:0][7:0]  b;
        logic [3:0][3:0]  gap;
        int               rdy;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Concatenations below list beats last-to-first.
        vecs[0] = '{mode:2'd0, acc:1'b1, init:32'd10, len:3, a:{32'd0, 32'd1, 32'd4, 32'd2},
                    b:{8'd0, 8'd1, 8'd5, 8'd3}, gap:16'h0000, rdy:0, exp:32'd37};
        vecs[1] = '{mode:2'd1, acc:1'b0, init:32'h55, len:2, a:{32'd0, 32'd0, 32'h0105, 32'h0203},
                    b:{8'd0, 8'd0, 8'd6, 8'd4}, gap:16'h0000, rdy:1, exp:32'h061E};
        vecs[2] = '{mode:2'd0, acc:1'b1, init:32'd7, len:0, a:'0, b:'0, gap:16'h0000, rdy:0, exp:32'd7};
        vecs[3] = '{mode:2'd0, acc:1'b0, init:32'd7, len:0, a:'0, b:'0, gap:16'h0000, rdy:0, exp:32'd0};
        vecs[4] = '{mode:2'd0, acc:1'b1, init:32'd1, len:4, a:{32'd7, 32'd5, 32'd3, 32'd1},
                    b:{8'd8, 8'd6, 8'd4, 8'd2}, gap:{4'd1, 4'd2, 4'd0, 4'd0}, rdy:5, exp:32'd101};
        vecs[5] = '{mode:2'd2, acc:1'b1, init:32'd0, len:1, a:{32'd0, 32'd0, 32'd0, 32'h01020304},
                    b:{8'd0, 8'd0, 8'd0, 8'd5}, gap:16'h0000, rdy:0, exp:32'h050A0F14};
        vecs[6] = '{mode:2'd3, acc:1'b1, init:32'd5, len:1, a:{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF},
                    b:{8'd0, 8'd0, 8'd0, 8'hFF}, gap:16'h0000, rdy:2, exp:32'd5};
        vecs[7] = '{mode:2'd2, acc:1'b0, init:32'h1234, len:2, a:{32'd0, 32'd0, 32'h01010101, 32'h11223344},
                    b:{8'd0, 8'd0, 8'd2, 8'd9}, gap:16'h0010, rdy:0, exp:32'h02020202};

        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_acc = 1'b0; cmd_init = '0; cmd_len = '0;
        op_valid = 1'b1; op_a = 32'hDEADBEEF; op_b = 8'h5A; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_en_clr", 64'({mac_en, mac_acc_clr}), 64'd0);
        check("rst_cfg", 64'(mac_cfg), 64'd0);
        check("rst_lanes", 64'({mac_quad2, mac_quad1, mac_dual, mac_a, mac_b}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 4; k++) begin
                ba[k] = vecs[v].a[k];
                bb[k] = vecs[v].b[k];
                bg[k] = int'(vecs[v].gap[k]);
            end
            run_job(vecs[v].mode, vecs[v].acc, vecs[v].init, vecs[v].len, vecs[v].rdy, vecs[v].exp);
        end

        // Back-to-back: second command held valid through the first job.
        ba[0] = 32'd3; bb[0] = 8'd3; bg[0] = 0;
        send_cmd(2'd0, 1'b1, 32'd0, 8'd1);
        cmd_init = 32'd0; cmd_len = 8'd1; cmd_valid = 1'b1;
        finish_job(2'd0, 1'b1, 32'd0, 1, 2, 32'd9);
        cmd_valid = 1'b0;
        ba[0] = 32'd2; bb[0] = 8'd2;
        finish_job(2'd0, 1'b1, 32'd0, 1, 0, 32'd4);

        // Abort a job after 1 of 3 beats.
        send_cmd(2'd0, 1'b1, 32'd100, 8'd3);
        @(negedge clk);
        @(posedge clk); #1;
        drive_beat(32'd3, 8'd3, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check("abort_op_ready", 64'(op_ready), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        ba[0] = 32'd6; bb[0] = 8'd7; bg[0] = 0;
        ba[1] = 32'd1; bb[1] = 8'd1; bg[1] = 1;
        run_job(2'd0, 1'b1, 32'd0, 2, 0, 32'd43);

        // Maximum length job must not wrap the beat counter.
        for (int k = 0; k < 255; k++) begin
            ba[k] = $urandom; bb[k] = 8'($urandom); bg[k] = 0;
        end
        run_job(2'd1, 1'b1, 32'd17, 255, 0, ref_result(2'd1, 1'b1, 32'd17, 255));

        for (int r = 0; r < 40; r++) begin
            logic [1:0]  m;
            logic        a;
            logic [31:0] i;
            int          l;
            m = 2'($urandom_range(0, 3));
            a = 1'($urandom_range(0, 1));
            i = $urandom;
            l = $urandom_range(0, 6);
            for (int k = 0; k < l; k++) begin
                ba[k] = $urandom; bb[k] = 8'($urandom); bg[k] = $urandom_range(0, 2);
            end
            run_job(m, a, i, l, $urandom_range(0, 3), ref_result(m, a, i, l));
        end

        check("cmd_ready_while_busy", 64'(busy_ready_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
